// File: rtl/play_mode_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// play_mode_ctrl_pkg
// Shared constants and types for the front-panel play-mode controller.
//   DB_*_DEFAULT / MAX_WIDTH_DEFAULT : default parameter values for the top
//   WIDTH_MIN, WIDTH_BITS            : loop width range; WIDTH_BITS also sizes
//                                      the sequencer's loop_width port
//   btn_state_t                      : per-button state, encoded as {db, db_d}
//   next_width()                     : loop width step with wrap to WIDTH_MIN
// -----------------------------------------------------------------------------
package play_mode_ctrl_pkg;

    localparam int DB_DIV_DEFAULT    = 65536;
    localparam int DB_DEPTH_DEFAULT  = 4;
    localparam int MAX_WIDTH_DEFAULT = 4;

    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_BITS = 3;

    typedef enum logic [1:0] {
        BTN_IDLE    = 2'b00,
        BTN_RELEASE = 2'b01,
        BTN_PRESS   = 2'b10,
        BTN_HELD    = 2'b11
    } btn_state_t;

    function automatic logic [WIDTH_BITS-1:0] next_width(
        input logic [WIDTH_BITS-1:0] w,
        input int                    max_w
    );
        return (w == WIDTH_BITS'(max_w)) ? WIDTH_BITS'(WIDTH_MIN) : w + 1'b1;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// One raw push-button: 2-flop synchronizer, tick-sampled shift register,
// debounced level and a one-cycle rising-edge press pulse.
//   clk, rst : clock, async active-high reset
//   tick     : shared sample strobe from the prescaler
//   btn      : raw button, asynchronous to clk
//   press    : high for exactly one cycle per debounced press
//
// state (= {db, db_d}) | meaning
// ---------------------+-----------------------------------------------
// BTN_IDLE    (0,0)    | released, shift register filling or empty
// BTN_PRESS   (1,0)    | shift register just filled, press emitted
// BTN_HELD    (1,1)    | still held, no repeat
// BTN_RELEASE (0,1)    | first cycle after a low sample cleared db
// -----------------------------------------------------------------------------
module button_conditioner
    import play_mode_ctrl_pkg::*;
#(
    parameter int DB_DEPTH = DB_DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    logic [1:0]          sync;
    logic [DB_DEPTH-1:0] sh;
    logic                db;
    logic                db_d;
    btn_state_t          state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
            sh   <= '0;
            db_d <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (tick) begin
                sh <= {sh[DB_DEPTH-2:0], sync[1]};
            end
            db_d <= db;
        end
    end

    // Any low sample inside the window clears db, so a bounce restarts the fill.
    assign db    = &sh;
    assign state = btn_state_t'({db, db_d});
    assign press = (state == BTN_PRESS);

endmodule

// File: rtl/play_mode_ctrl.sv
// -----------------------------------------------------------------------------
// play_mode_ctrl
// Front-panel control stage ahead of the beat-index sequencer. Conditions five
// raw buttons and holds the mode levels the sequencer consumes.
//   clk, rst        : clock, async active-high reset
//   btn_play        : toggles play_pause
//   btn_loop        : toggles loop_de
//   btn_rev         : toggles reverse
//   btn_width       : steps loop_width 1..MAX_WIDTH, only while not looping
//   btn_stop        : clears play/loop/reverse, pulses clear_beat
//   play_pause      : 1 = playing
//   loop_de         : 1 = loop mode engaged
//   loop_width      : loop width in notes, never 0
//   reverse         : 1 = beat index decrements
//   clear_beat      : one-cycle request to zero the beat index
// -----------------------------------------------------------------------------
module play_mode_ctrl
    import play_mode_ctrl_pkg::*;
#(
    parameter int DB_DIV    = DB_DIV_DEFAULT,
    parameter int DB_DEPTH  = DB_DEPTH_DEFAULT,
    parameter int MAX_WIDTH = MAX_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_play,
    input  logic                  btn_loop,
    input  logic                  btn_rev,
    input  logic                  btn_width,
    input  logic                  btn_stop,
    output logic                  play_pause,
    output logic                  loop_de,
    output logic [WIDTH_BITS-1:0] loop_width,
    output logic                  reverse,
    output logic                  clear_beat
);

    localparam int CNT_W = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic             p_play;
    logic             p_loop;
    logic             p_rev;
    logic             p_width;
    logic             p_stop;

    assign tick = (div_cnt == CNT_W'(DB_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    button_conditioner #(.DB_DEPTH(DB_DEPTH)) u_play (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_play), .press(p_play)
    );
    button_conditioner #(.DB_DEPTH(DB_DEPTH)) u_loop (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_loop), .press(p_loop)
    );
    button_conditioner #(.DB_DEPTH(DB_DEPTH)) u_rev (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_rev), .press(p_rev)
    );
    button_conditioner #(.DB_DEPTH(DB_DEPTH)) u_width (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_width), .press(p_width)
    );
    button_conditioner #(.DB_DEPTH(DB_DEPTH)) u_stop (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_stop), .press(p_stop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            play_pause <= 1'b0;
            loop_de    <= 1'b0;
            reverse    <= 1'b0;
            clear_beat <= 1'b0;
            loop_width <= WIDTH_BITS'(WIDTH_MIN);
        end else begin
            clear_beat <= 1'b0;
            if (p_stop) begin
                // Stop wins and swallows every other press this cycle.
                play_pause <= 1'b0;
                loop_de    <= 1'b0;
                reverse    <= 1'b0;
                clear_beat <= 1'b1;
            end else begin
                if (p_play) play_pause <= ~play_pause;
                if (p_rev)  reverse    <= ~reverse;
                if (p_loop) loop_de    <= ~loop_de;
                // Uses the pre-update loop_de so the loop bound never moves mid-loop.
                if (p_width && !loop_de) begin
                    loop_width <= next_width(loop_width, MAX_WIDTH);
                end
            end
        end
    end

endmodule

// File: tb/tb_play_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_play_mode_ctrl
// Directed bench for play_mode_ctrl with DB_DIV = 4, DB_DEPTH = 4.
// -----------------------------------------------------------------------------
module tb_play_mode_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_play;
    logic       btn_loop;
    logic       btn_rev;
    logic       btn_width;
    logic       btn_stop;
    logic       play_pause;
    logic       loop_de;
    logic [2:0] loop_width;
    logic       reverse;
    logic       clear_beat;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    play_mode_ctrl #(.DB_DIV(4), .DB_DEPTH(4), .MAX_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .btn_play(btn_play), .btn_loop(btn_loop), .btn_rev(btn_rev),
        .btn_width(btn_width), .btn_stop(btn_stop),
        .play_pause(play_pause), .loop_de(loop_de), .loop_width(loop_width),
        .reverse(reverse), .clear_beat(clear_beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return play_pause;
            1:       return loop_de;
            2:       return reverse;
            default: return 1'b0;
        endcase
    endfunction

    // Counts changes of the selected mode output over n cycles; first = cycle of first change.
    task automatic watch(input int s, input int n, output int toggles, output int first);
        logic prev;
        prev    = sig(s);
        toggles = 0;
        first   = 0;
        for (int i = 1; i <= n; i++) begin
            step(1);
            if (sig(s) !== prev) begin
                toggles++;
                if (first == 0) first = i;
                prev = sig(s);
            end
        end
    endtask

    // mask = {stop, width, rev, loop, play}; hold long enough for one press, then drain.
    task automatic press(input logic [4:0] mask);
        {btn_stop, btn_width, btn_rev, btn_loop, btn_play} = mask;
        step(24);
        {btn_stop, btn_width, btn_rev, btn_loop, btn_play} = 5'b0;
        step(24);
    endtask

    initial begin
        int t;
        int f;
        int tog;
        int cb_cnt;

        rst = 1'b1;
        {btn_stop, btn_width, btn_rev, btn_loop, btn_play} = 5'b0;
        step(3);
        check("rst_play_pause", play_pause, 0);
        check("rst_loop_de",    loop_de,    0);
        check("rst_loop_width", loop_width, 1);
        check("rst_reverse",    reverse,    0);
        check("rst_clear_beat", clear_beat, 0);
        rst = 1'b0;
        step(2);

        // Clean play press, then a second press.
        btn_play = 1'b1;
        watch(0, 40, t, f);
        check("play1_toggles", t, 1);
        check_range("play1_latency", f, 16, 20);
        check("play1_level", play_pause, 1);
        btn_play = 1'b0;
        step(30);
        btn_play = 1'b1;
        watch(0, 40, t, f);
        check("play2_toggles", t, 1);
        check("play2_level", play_pause, 0);
        btn_play = 1'b0;
        step(30);

        // Bounce on reverse: 3-cycle high/low slots never hold 4 high ticks.
        tog = 0;
        for (int k = 0; k < 10; k++) begin
            btn_rev = ~btn_rev;
            watch(2, 3, t, f);
            tog += t;
        end
        check("bounce_no_toggle", tog, 0);
        btn_rev = 1'b1;
        watch(2, 40, t, f);
        check("bounce_toggles", t, 1);
        check_range("bounce_latency", f, 12, 20);
        check("bounce_level", reverse, 1);
        btn_rev = 1'b0;
        step(30);

        // Width wrap.
        press(5'b01000); check("width_step1", loop_width, 2);
        press(5'b01000); check("width_step2", loop_width, 3);
        press(5'b01000); check("width_step3", loop_width, 4);
        press(5'b01000); check("width_wrap",  loop_width, 1);

        // Width locked while looping.
        press(5'b00010); check("loop_on", loop_de, 1);
        press(5'b01000); check("width_locked", loop_width, 1);
        press(5'b01010);
        check("loop_width_same_cycle_loop", loop_de, 0);
        check("loop_width_same_cycle_width", loop_width, 1);
        press(5'b01000); check("width_unlocked", loop_width, 2);

        // Stop priority over a simultaneous play press.
        press(5'b00001);
        press(5'b00010);
        check("pre_stop_play", play_pause, 1);
        check("pre_stop_loop", loop_de, 1);
        check("pre_stop_rev",  reverse, 1);
        btn_stop = 1'b1;
        btn_play = 1'b1;
        cb_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(1);
            if (clear_beat === 1'b1) cb_cnt++;
        end
        btn_stop = 1'b0;
        btn_play = 1'b0;
        step(24);
        check("stop_clear_beat_cycles", cb_cnt, 1);
        check("stop_play",  play_pause, 0);
        check("stop_loop",  loop_de, 0);
        check("stop_rev",   reverse, 0);
        check("stop_width", loop_width, 2);

        // Long hold, then reset mid-hold and a fresh press after refill.
        btn_loop = 1'b1;
        watch(1, 500, t, f);
        check("hold_toggles", t, 1);
        check("hold_level", loop_de, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_play_pause", play_pause, 0);
        check("async_rst_loop_de",    loop_de,    0);
        check("async_rst_loop_width", loop_width, 1);
        check("async_rst_reverse",    reverse,    0);
        check("async_rst_clear_beat", clear_beat, 0);
        step(3);
        rst = 1'b0;
        watch(1, 40, t, f);
        check("post_rst_toggles", t, 1);
        check("post_rst_level", loop_de, 1);
        btn_loop = 1'b0;
        step(10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
